// File: rtl/control_sequencer.sv
// control_sequencer
//   Instruction sequencer for the 8-bit CPU. Owns the FETCH/DECODE/EXECUTE/
//   WRITEBACK/OUTPUT/HALT state register, the instruction register and a
//   run-time-loadable decode table. Adds memory wait-states, a HALT state,
//   illegal-opcode trapping with a saturating counter and an optional OUTPUT stage.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   leave HALT
//   mem_ready   in   instr is valid this cycle (sampled in FETCH only)
//   instr       in   instruction from memory
//   tbl_we      in   decode-table write enable (honoured in HALT only)
//   tbl_addr    in   decode-table write address
//   tbl_wdata   in   entry {halt, wb, execute word}
//   ctrl        out  control word for the current cycle
//   state       out  FETCH=0 DECODE=1 EXECUTE=2 WRITEBACK=3 OUTPUT=4 HALT=5
//   ir          out  instruction register
//   illegal     out  high in DECODE when the ir entry is illegal
//   retired     out  high in the last cycle of a legal instruction
//   halted      out  state == HALT
//   illegal_cnt out  saturating count of illegal instructions
module control_sequencer #(
  parameter int unsigned       INSTR_W       = 8,
  parameter int unsigned       CTRL_W        = 16,
  parameter bit                OUT_EN        = 1'b1,
  parameter bit                ILLEGAL_HALT  = 1'b0,
  parameter logic [CTRL_W-1:0] FETCH_WORD    = 16'h0400,
  parameter logic [CTRL_W-1:0] DECODE_WORD   = 16'h0000,
  parameter logic [CTRL_W-1:0] DECODE_I_WORD = 16'h0200,
  parameter logic [CTRL_W-1:0] WB_WORD       = 16'h3880,
  parameter logic [CTRL_W-1:0] OUT_WORD      = 16'h0080
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               mem_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               tbl_we,
  input  logic [INSTR_W-1:0] tbl_addr,
  input  logic [CTRL_W+1:0]  tbl_wdata,
  output logic [CTRL_W-1:0]  ctrl,
  output logic [2:0]         state,
  output logic [INSTR_W-1:0] ir,
  output logic               illegal,
  output logic               retired,
  output logic               halted,
  output logic [7:0]         illegal_cnt
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StWriteback = 3'd3,
    StOutput    = 3'd4,
    StHalt      = 3'd5
  } state_e;

  state_e             r_state;
  state_e             w_state_d;
  logic [INSTR_W-1:0] r_ir;
  logic [7:0]         r_cnt;
  logic               w_ir_load;
  logic               w_cnt_inc;

  // Decode table: not reset, so contents survive rst.
  logic [CTRL_W+1:0]  r_tbl [2**INSTR_W];
  logic [CTRL_W+1:0]  w_entry;
  logic               w_entry_halt;
  logic               w_entry_wb;
  logic               w_entry_bad;

  always_ff @(posedge clk) begin
    if (tbl_we && (r_state == StHalt)) begin
      r_tbl[tbl_addr] <= tbl_wdata;
    end
  end

  assign w_entry      = r_tbl[r_ir];
  assign w_entry_halt = w_entry[CTRL_W+1];
  assign w_entry_wb   = w_entry[CTRL_W];
  // All-zero entries are illegal except at address 0, which is the NOP.
  assign w_entry_bad  = (w_entry == '0) && (r_ir != '0);

  always_comb begin
    w_state_d = r_state;
    w_ir_load = 1'b0;
    w_cnt_inc = 1'b0;
    ctrl      = '0;
    illegal   = 1'b0;
    retired   = 1'b0;
    halted    = 1'b0;
    case (r_state)
      StFetch: begin
        ctrl = FETCH_WORD;
        if (mem_ready) begin
          w_ir_load = 1'b1;
          w_state_d = StDecode;
        end
      end
      StDecode: begin
        if (w_entry_bad) begin
          illegal   = 1'b1;
          w_cnt_inc = 1'b1;
          w_state_d = ILLEGAL_HALT ? StHalt : StFetch;
        end else begin
          ctrl      = (r_ir[INSTR_W-1 -: 2] == 2'b00) ? DECODE_I_WORD : DECODE_WORD;
          w_state_d = StExecute;
        end
      end
      StExecute: begin
        ctrl = w_entry[CTRL_W-1:0];
        if (w_entry_halt) begin
          retired   = 1'b1;
          w_state_d = StHalt;
        end else if (w_entry_wb) begin
          w_state_d = StWriteback;
        end else begin
          retired   = 1'b1;
          w_state_d = StFetch;
        end
      end
      StWriteback: begin
        ctrl = WB_WORD;
        if (OUT_EN) begin
          w_state_d = StOutput;
        end else begin
          retired   = 1'b1;
          w_state_d = StFetch;
        end
      end
      StOutput: begin
        ctrl      = OUT_WORD;
        retired   = 1'b1;
        w_state_d = StFetch;
      end
      StHalt: begin
        halted = 1'b1;
        if (start) begin
          w_state_d = StFetch;
        end
      end
      // Unreachable encodings fall back to HALT.
      default: w_state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StHalt;
      r_ir    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_ir_load) begin
        r_ir <= instr;
      end
      if (w_cnt_inc && (r_cnt != 8'hFF)) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign state       = r_state;
  assign ir          = r_ir;
  assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer. Two instances share clock and reset:
//   dut0: OUT_EN=1, ILLEGAL_HALT=0    dut1: OUT_EN=0, ILLEGAL_HALT=1
// Expected behaviour comes from an instruction-level model: for each
// instruction the bench derives the cycle-by-cycle trace from the table
// entry and compares it against the DUT.
module tb_control_sequencer;

  logic        clk;
  logic        rst;
  logic        start_v   [2];
  logic        mr_v      [2];
  logic [7:0]  instr_v   [2];
  logic        we_v      [2];
  logic [7:0]  addr_v    [2];
  logic [17:0] wdata_v   [2];
  logic [15:0] ctrl_v    [2];
  logic [2:0]  state_v   [2];
  logic [7:0]  ir_v      [2];
  logic        illegal_v [2];
  logic        retired_v [2];
  logic        halted_v  [2];
  logic [7:0]  cnt_v     [2];

  // Reference model
  logic [17:0] tbl_m    [2][256];
  logic [7:0]  ir_m     [2];
  int          cnt_m    [2];
  bit          halted_m [2];

  int n_checks;
  int n_fail;

  control_sequencer #(.OUT_EN(1'b1), .ILLEGAL_HALT(1'b0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .start      (start_v[0]),
    .mem_ready  (mr_v[0]),
    .instr      (instr_v[0]),
    .tbl_we     (we_v[0]),
    .tbl_addr   (addr_v[0]),
    .tbl_wdata  (wdata_v[0]),
    .ctrl       (ctrl_v[0]),
    .state      (state_v[0]),
    .ir         (ir_v[0]),
    .illegal    (illegal_v[0]),
    .retired    (retired_v[0]),
    .halted     (halted_v[0]),
    .illegal_cnt(cnt_v[0])
  );

  control_sequencer #(.OUT_EN(1'b0), .ILLEGAL_HALT(1'b1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start_v[1]),
    .mem_ready  (mr_v[1]),
    .instr      (instr_v[1]),
    .tbl_we     (we_v[1]),
    .tbl_addr   (addr_v[1]),
    .tbl_wdata  (wdata_v[1]),
    .ctrl       (ctrl_v[1]),
    .state      (state_v[1]),
    .ir         (ir_v[1]),
    .illegal    (illegal_v[1]),
    .retired    (retired_v[1]),
    .halted     (halted_v[1]),
    .illegal_cnt(cnt_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  function automatic bit out_en(int d);
    return d == 0;
  endfunction

  function automatic bit ill_halt(int d);
    return d == 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cyc(input int d, input string tag, input logic [15:0] e_ctrl,
                           input logic [2:0] e_st, input logic e_ret, input logic e_ill);
    check_eq($sformatf("d%0d %s ctrl", d, tag), ctrl_v[d], e_ctrl);
    check_eq($sformatf("d%0d %s state", d, tag), state_v[d], e_st);
    check_eq($sformatf("d%0d %s retired", d, tag), retired_v[d], e_ret);
    check_eq($sformatf("d%0d %s illegal", d, tag), illegal_v[d], e_ill);
    check_eq($sformatf("d%0d %s halted", d, tag), halted_v[d], e_st == 3'd5);
    check_eq($sformatf("d%0d %s ir", d, tag), ir_v[d], ir_m[d]);
    check_eq($sformatf("d%0d %s cnt", d, tag), cnt_v[d], cnt_m[d]);
  endtask

  // One HALT cycle with a table write, staying in HALT.
  task automatic tbl_write(input int d, input logic [7:0] a, input logic [17:0] data);
    start_v[d] = 1'b0;
    mr_v[d]    = 1'($urandom);
    we_v[d]    = 1'b1;
    addr_v[d]  = a;
    wdata_v[d] = data;
    check_cyc(d, "halt_wr", 16'h0000, 3'd5, 1'b0, 1'b0);
    tick();
    tbl_m[d][a] = data;
    we_v[d]     = 1'b0;
  endtask

  // Leave HALT, optionally writing the table in the same cycle.
  task automatic resume(input int d, input bit we, input logic [7:0] a, input logic [17:0] data);
    start_v[d] = 1'b1;
    mr_v[d]    = 1'($urandom);
    we_v[d]    = we;
    addr_v[d]  = a;
    wdata_v[d] = data;
    check_cyc(d, "halt", 16'h0000, 3'd5, 1'b0, 1'b0);
    tick();
    if (we) tbl_m[d][a] = data;
    start_v[d]  = 1'b0;
    we_v[d]     = 1'b0;
    halted_m[d] = 1'b0;
  endtask

  // Runs one instruction from FETCH: nwait not-ready cycles, then acceptance.
  // bad_wr issues a table write during the first wait cycle, which must be ignored.
  task automatic run_instr(input int d, input logic [7:0] op, input int nwait, input bit bad_wr);
    logic [17:0] e;
    bit          ill;
    for (int i = 0; i < nwait; i++) begin
      mr_v[d]    = 1'b0;
      instr_v[d] = 8'($urandom);
      start_v[d] = 1'($urandom);
      if (bad_wr && i == 0) begin
        we_v[d]    = 1'b1;
        addr_v[d]  = op;
        wdata_v[d] = 18'($urandom);
      end
      check_cyc(d, "fetch_wait", 16'h0400, 3'd0, 1'b0, 1'b0);
      tick();
      we_v[d] = 1'b0;
    end
    mr_v[d]    = 1'b1;
    instr_v[d] = op;
    start_v[d] = 1'($urandom);
    check_cyc(d, "fetch", 16'h0400, 3'd0, 1'b0, 1'b0);
    tick();
    ir_m[d]    = op;
    mr_v[d]    = 1'($urandom);
    instr_v[d] = 8'($urandom);
    e   = tbl_m[d][op];
    ill = (e == 18'd0) && (op != 8'd0);
    if (ill) begin
      check_cyc(d, "decode_ill", 16'h0000, 3'd1, 1'b0, 1'b1);
      tick();
      if (cnt_m[d] < 255) cnt_m[d]++;
      halted_m[d] = ill_halt(d);
    end else begin
      check_cyc(d, "decode", (op[7:6] == 2'b00) ? 16'h0200 : 16'h0000, 3'd1, 1'b0, 1'b0);
      tick();
      check_cyc(d, "execute", e[15:0], 3'd2, e[17] | ~e[16], 1'b0);
      tick();
      if (e[17]) begin
        halted_m[d] = 1'b1;
      end else if (e[16]) begin
        check_cyc(d, "writeback", 16'h3880, 3'd3, !out_en(d), 1'b0);
        tick();
        if (out_en(d)) begin
          check_cyc(d, "output", 16'h0080, 3'd4, 1'b1, 1'b0);
          tick();
        end
      end
    end
    mr_v[d]    = 1'b0;
    start_v[d] = 1'b0;
    if (halted_m[d]) check_cyc(d, "after_halt", 16'h0000, 3'd5, 1'b0, 1'b0);
    else             check_cyc(d, "after", 16'h0400, 3'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [7:0] pick_illegal(int d);
    logic [7:0] a;
    do a = 8'($urandom_range(1, 255)); while (tbl_m[d][a] != 18'd0);
    return a;
  endfunction

  task automatic reset_model();
    for (int d = 0; d < 2; d++) begin
      ir_m[d]     = 8'd0;
      cnt_m[d]    = 0;
      halted_m[d] = 1'b1;
    end
  endtask

  logic [7:0] pool [$];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int d = 0; d < 2; d++) begin
      start_v[d] = 1'b0;
      mr_v[d]    = 1'b0;
      instr_v[d] = 8'd0;
      we_v[d]    = 1'b0;
      addr_v[d]  = 8'd0;
      wdata_v[d] = 18'd0;
      for (int a = 0; a < 256; a++) tbl_m[d][a] = 18'd0;
    end
    reset_model();

    // Reset values before any clock edge.
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) check_cyc(d, "reset", 16'h0000, 3'd5, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Clear the whole table in both instances (it is not reset).
    for (int a = 0; a < 256; a++) begin
      for (int d = 0; d < 2; d++) begin
        we_v[d]    = 1'b1;
        addr_v[d]  = 8'(a);
        wdata_v[d] = 18'd0;
      end
      tick();
    end
    for (int d = 0; d < 2; d++) we_v[d] = 1'b0;

    // Directed scenarios.
    for (int d = 0; d < 2; d++) begin
      tbl_write(d, 8'h55, {2'b01, 16'h0055});
      tbl_write(d, 8'h13, {2'b00, 16'h0013});
      tbl_write(d, 8'hF0, {2'b10, 16'h00F0});
      resume(d, 1'b0, 8'h00, 18'd0);
      run_instr(d, 8'h55, 0, 1'b0);
      run_instr(d, 8'h13, 3, 1'b1);
      run_instr(d, 8'h00, 0, 1'b0);
      run_instr(d, 8'h37, 1, 1'b0);
      if (!halted_m[d]) run_instr(d, 8'hF0, 0, 1'b0);
      resume(d, 1'b1, 8'h37, {2'b00, 16'h1337});
      run_instr(d, 8'h37, 0, 1'b0);
    end

    // Reset asserted while dut0 is in EXECUTE.
    mr_v[0]    = 1'b1;
    instr_v[0] = 8'h55;
    tick();
    mr_v[0] = 1'b0;
    tick();
    check_eq("d0 pre_rst state", state_v[0], 3'd2);
    #2;
    rst = 1'b1;
    #1;
    reset_model();
    for (int d = 0; d < 2; d++) check_cyc(d, "async_rst", 16'h0000, 3'd5, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    tick();

    // Illegal-count saturation on dut0; trapping into HALT on dut1.
    resume(0, 1'b0, 8'h00, 18'd0);
    for (int i = 0; i < 260; i++) run_instr(0, pick_illegal(0), $urandom_range(0, 1), 1'b0);
    check_eq("d0 cnt_sat", cnt_v[0], 32'd255);
    for (int i = 0; i < 3; i++) begin
      resume(1, 1'b0, 8'h00, 18'd0);
      run_instr(1, pick_illegal(1), 0, 1'b0);
    end
    check_eq("d1 cnt3", cnt_v[1], 32'd3);

    // Randomized programs against the model.
    run_instr(0, 8'hF0, 0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      pool.delete();
      for (int i = 0; i < 20; i++) begin
        logic [7:0]  a;
        logic [17:0] e;
        a = 8'($urandom);
        e = {($urandom_range(0, 7) == 0), 1'($urandom), 16'($urandom)};
        tbl_write(d, a, e);
        pool.push_back(a);
      end
      resume(d, 1'b0, 8'h00, 18'd0);
      for (int i = 0; i < 150; i++) begin
        if (halted_m[d]) begin
          logic [7:0] a;
          a = 8'($urandom);
          resume(d, 1'($urandom), a, {($urandom_range(0, 7) == 0), 1'($urandom), 16'($urandom)});
        end else begin
          logic [7:0] op;
          if ($urandom_range(0, 9) < 6) op = pool[$urandom_range(0, pool.size() - 1)];
          else                          op = 8'($urandom);
          run_instr(d, op, $urandom_range(0, 2), 1'b0);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
